// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, FSM state type and pointer helper for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Advance a requester index by one, wrapping from N-1 back to 0.
    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(N - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0, take the
// lowest set bit, then rotate the one-hot result back into requester order.
module rr_pick
    import rr_arbiter_8_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [N-1:0]     rot;
    logic [N-1:0]     pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             found;

    // Rotate, fixed-priority pick from bit 0 upward, rotate back.
    always_comb begin
        rot        = '0;
        pick_oh    = '0;
        pick_idx   = '0;
        found      = 1'b0;
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                found    = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
        pick_oh[pick_idx] = found;
        for (int i = 0; i < N; i++) begin
            win_onehot[IDX_W'(i) + ptr] = pick_oh[i];
        end
        win_idx = pick_idx + ptr;
        any     = found;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a registered one-hot grant that is held
// until the owner pulses done or drops its request; one idle bubble between grants.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic         busy
);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] hold_idx, hold_idx_n;
    logic [N-1:0]     gnt_q, gnt_n;

    logic [N-1:0]     win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             any;

    rr_pick u_pick (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (any)
    );

    // Next-state logic: arbitrate in IDLE, hold the grant in GRANT until release.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_idx_n = hold_idx;
        gnt_n      = gnt_q;
        unique case (state)
            IDLE: begin
                if (any) begin
                    gnt_n      = win_onehot;
                    hold_idx_n = win_idx;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (done || !req[hold_idx]) begin
                    gnt_n   = '0;
                    ptr_n   = inc_wrap(hold_idx);
                    state_n = IDLE;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer and grant registers; reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_idx <= '0;
            gnt_q    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_idx <= hold_idx_n;
            gnt_q    <= gnt_n;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign busy      = (state == GRANT);

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("gnt has more than one bit set: %b", gnt);

    a_flags_agree : assert property (@(posedge clk) disable iff (rst)
        (gnt_valid == (|gnt)) && (busy == gnt_valid))
        else $error("gnt_valid/busy disagree with gnt: %b %b %b", gnt, gnt_valid, busy);

    a_gnt_stable : assert property (@(posedge clk) disable iff (rst)
        busy |=> ((gnt == $past(gnt)) || (gnt == '0)))
        else $error("gnt changed while busy: %b", gnt);

endmodule
